// File: rtl/mux_oht.sv
// One-hot select multiplexer with a registered valid flag and data output.
// The combinational core is either a flat AND-OR or a SPLIT-ary reduction tree.
module mux_oht #(
    parameter type DAT_T          = logic [7:0],
    parameter int  WIDTH          = 9,
    parameter int  SPLIT          = 3,
    parameter int  IMPLEMENTATION = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [WIDTH-1:0] oht,
    input  DAT_T ary [WIDTH-1:0],
    output logic vld,
    output DAT_T dat
);

    // Number of tree levels: smallest L >= 1 with SPLIT**L >= WIDTH.
    function automatic int levels_f(input int w, input int s);
        int n;
        int l;
        n = 1;
        l = 0;
        while (n < w) begin
            n = n * s;
            l = l + 1;
        end
        return (l == 0) ? 1 : l;
    endfunction

    localparam int LEVELS = levels_f(WIDTH, SPLIT);
    localparam int PAD    = SPLIT ** LEVELS;

    logic vld_c;
    DAT_T dat_c;

    if (WIDTH < 1) begin : g_bad_width
        $error("mux_oht: WIDTH must be >= 1");
    end
    if (SPLIT < 2) begin : g_bad_split
        $error("mux_oht: SPLIT must be >= 2");
    end

    if (IMPLEMENTATION == 0) begin : g_flat
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        always_comb begin
            vld_c = |oht;
            dat_c = '0;
            for (int i = 0; i < WIDTH; i++) begin
                dat_c = dat_c | (ary[i] & {$bits(DAT_T){oht[i]}});
            end
        end
    end else if (IMPLEMENTATION == 1) begin : g_tree
        logic tv [PAD];
        DAT_T td [PAD];

        // Levels reduce in place: group g of a level lands in slot g, and its
        // inputs sit at g*SPLIT and above, so no live slot is overwritten early.
        always_comb begin
            logic gv;
            DAT_T gd;
            for (int i = 0; i < PAD; i++) begin
                tv[i] = 1'b0;
                td[i] = '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                tv[i] = oht[i];
                td[i] = ary[i];
            end
            for (int l = 0; l < LEVELS; l++) begin
                for (int g = 0; g < PAD / SPLIT; g++) begin
                    if (g < PAD / (SPLIT ** (l + 1))) begin
                        gv = 1'b0;
                        gd = '0;
                        for (int k = 0; k < SPLIT; k++) begin
                            gv = gv | tv[g*SPLIT+k];
                            gd = gd | (td[g*SPLIT+k] & {$bits(DAT_T){tv[g*SPLIT+k]}});
                        end
                        tv[g] = gv;
                        td[g] = gd;
                    end
                end
            end
            vld_c = tv[0];
            dat_c = td[0];
        end
    end else begin : g_bad_impl
        $error("mux_oht: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            vld <= vld_c;
            dat <= dat_c;
        end
    end

endmodule

// File: tb/tb_mux_oht.sv
// Side-by-side check of both mux_oht structures at several widths against a
// behavioural model: result = OR of the selected elements, valid = any selected.
module tb_mux_oht;

    localparam int N_INST = 8;

    logic clk;
    logic rst_n;

    logic [9:0] m_oht;
    logic [7:0] m_ary [10];

    logic [8:0] oht9;
    logic [7:0] ary9 [8:0];
    logic [0:0] oht1;
    logic [7:0] ary1 [0:0];
    logic [3:0] oht4;
    logic [7:0] ary4 [3:0];
    logic [9:0] oht10;
    logic [7:0] ary10 [9:0];

    logic       vld_o [N_INST];
    logic [7:0] dat_o [N_INST];
    logic [8:0] exp_q [N_INST];

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(9), .SPLIT(3), .IMPLEMENTATION(0)) u_w9_i0 (
        .clk(clk), .rst_n(rst_n), .oht(oht9), .ary(ary9), .vld(vld_o[0]), .dat(dat_o[0]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(9), .SPLIT(3), .IMPLEMENTATION(1)) u_w9_i1 (
        .clk(clk), .rst_n(rst_n), .oht(oht9), .ary(ary9), .vld(vld_o[1]), .dat(dat_o[1]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(1), .SPLIT(3), .IMPLEMENTATION(0)) u_w1_i0 (
        .clk(clk), .rst_n(rst_n), .oht(oht1), .ary(ary1), .vld(vld_o[2]), .dat(dat_o[2]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(1), .SPLIT(3), .IMPLEMENTATION(1)) u_w1_i1 (
        .clk(clk), .rst_n(rst_n), .oht(oht1), .ary(ary1), .vld(vld_o[3]), .dat(dat_o[3]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(4), .SPLIT(3), .IMPLEMENTATION(0)) u_w4_i0 (
        .clk(clk), .rst_n(rst_n), .oht(oht4), .ary(ary4), .vld(vld_o[4]), .dat(dat_o[4]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(4), .SPLIT(3), .IMPLEMENTATION(1)) u_w4_i1 (
        .clk(clk), .rst_n(rst_n), .oht(oht4), .ary(ary4), .vld(vld_o[5]), .dat(dat_o[5]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(10), .SPLIT(2), .IMPLEMENTATION(0)) u_w10_i0 (
        .clk(clk), .rst_n(rst_n), .oht(oht10), .ary(ary10), .vld(vld_o[6]), .dat(dat_o[6]));
    mux_oht #(.DAT_T(logic [7:0]), .WIDTH(10), .SPLIT(2), .IMPLEMENTATION(1)) u_w10_i1 (
        .clk(clk), .rst_n(rst_n), .oht(oht10), .ary(ary10), .vld(vld_o[7]), .dat(dat_o[7]));

    function automatic int width_of(input int k);
        case (k)
            0, 1:    return 9;
            2, 3:    return 1;
            4, 5:    return 4;
            default: return 10;
        endcase
    endfunction

    // Reference: collect the selected indices, then fold their data with OR.
    function automatic logic [8:0] ref_model(input int w);
        int         sel [$];
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < w; i++) begin
            if (m_oht[i]) sel.push_back(i);
        end
        foreach (sel[j]) acc = acc | m_ary[sel[j]];
        return {sel.size() != 0, acc};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got vld=%b dat=%h, expected vld=%b dat=%h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic apply(input logic [9:0] o);
        m_oht = o;
        oht9  = o[8:0];
        oht1  = o[0:0];
        oht4  = o[3:0];
        oht10 = o;
        for (int i = 0; i < 10; i++) begin
            ary10[i] = m_ary[i];
            if (i < 9) ary9[i] = m_ary[i];
            if (i < 4) ary4[i] = m_ary[i];
            if (i < 1) ary1[i] = m_ary[i];
        end
        for (int k = 0; k < N_INST; k++) exp_q[k] = ref_model(width_of(k));
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N_INST; k++) begin
            check($sformatf("%s/w%0d_impl%0d", tag, width_of(k), k % 2),
                  {vld_o[k], dat_o[k]}, exp_q[k]);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < N_INST; k++) begin
            check($sformatf("%s/w%0d_impl%0d", tag, width_of(k), k % 2),
                  {vld_o[k], dat_o[k]}, 9'h000);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [9:0] o;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 10; i++) m_ary[i] = 8'(i);
        apply(10'h010);

        #2;
        check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("reset_release");

        // Asynchronous assertion mid-cycle clears outputs without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("reset_reload");

        apply(10'h000);
        cycle("idle");

        for (int i = 0; i < 10; i++) begin
            apply(10'(1 << i));
            cycle($sformatf("sweep%0d", i));
        end

        apply(10'h006);
        cycle("multi_006");
        apply(10'h1FF);
        cycle("multi_1ff");
        apply(10'h3FF);
        cycle("multi_3ff");
        apply(10'h000);
        cycle("idle_after_multi");

        m_ary[5] = 'x;
        apply(10'h001);
        cycle("x_isolation");
        m_ary[5] = 8'h05;

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 10; i++) m_ary[i] = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       o = 10'h000;
                1:       o = 10'(1 << $urandom_range(0, 9));
                default: o = 10'($urandom);
            endcase
            apply(o);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
